// File: rtl/mux_2to1_sync.sv
// rtl/mux_2to1_sync.sv - two-input word mux with combinational and registered outputs
module mux_2to1_sync #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q
);

  // Whole-word select. The conditional operator is used deliberately
  // so an unknown sel merges i0/i1 bitwise (agreeing bits pass through,
  // others go X) instead of silently defaulting to i0.
  logic [WIDTH-1:0] y_sel;

  // Combinational select path, valid regardless of clk, rst and en
  always_comb begin
    y_sel = sel ? i1 : i0;
  end

  assign y = y_sel;

  // Registered copy of the selection; reset wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= RST_VAL;
      sel_q <= 1'b0;
    end else if (en) begin
      y_q   <= y_sel;
      sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_mux_2to1_sync.sv
// tb/tb_mux_2to1_sync.sv - directed scoreboard bench for mux_2to1_sync
module tb_mux_2to1_sync;

  localparam int unsigned W8      = 8;
  localparam logic [7:0]  RST_A5  = 8'hA5;

  logic clk = 1'b0;
  logic rst;

  // WIDTH=1 instance: truth table only, enable held low
  logic w1_en, w1_i0, w1_i1, w1_sel;
  logic w1_y, w1_y_q, w1_sel_q;

  // WIDTH=8 instance: registered-path tests
  logic         en;
  logic [7:0]   i0, i1;
  logic         sel;
  logic [7:0]   y, y_q;
  logic         sel_q;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] yq;
    logic       sq;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl_yq;
  logic       mdl_sq;

  always #5 clk = ~clk;

  mux_2to1_sync #(.WIDTH(1), .RST_VAL(1'b0)) u_w1 (
    .clk   (clk),
    .rst   (rst),
    .en    (w1_en),
    .i0    (w1_i0),
    .i1    (w1_i1),
    .sel   (w1_sel),
    .y     (w1_y),
    .y_q   (w1_y_q),
    .sel_q (w1_sel_q)
  );

  mux_2to1_sync #(.WIDTH(W8), .RST_VAL(RST_A5)) u_w8 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i0    (i0),
    .i1    (i1),
    .sel   (sel),
    .y     (y),
    .y_q   (y_q),
    .sel_q (sel_q)
  );

  task automatic w1_vec(input logic a0, input logic a1, input logic s, input logic exp_y);
    w1_i0  = a0;
    w1_i1  = a1;
    w1_sel = s;
    #1;
    n_vec++;
    assert (w1_y === exp_y) else begin
      n_fail++;
      $error("FAIL w1_y[%b%b%b]: observed %b expected %b", a0, a1, s, w1_y, exp_y);
    end
    #9;
  endtask

  // One clock step on the 8-bit instance. Starts just after a rising
  // edge: checks y, pushes the expected register contents, waits for
  // the next edge and pops/compares y_q and sel_q.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic s, input logic [7:0] exp_y);
    exp_t ex;
    exp_t got;
    rst = r;
    en  = e;
    i0  = a0;
    i1  = a1;
    sel = s;
    #1;
    n_vec++;
    assert (y === exp_y) else begin
      n_fail++;
      $error("FAIL %s y: observed %h expected %h", tag, y, exp_y);
    end
    if (r) begin
      mdl_yq = RST_A5;
      mdl_sq = 1'b0;
    end else if (e) begin
      mdl_yq = exp_y;
      mdl_sq = s;
    end
    ex.yq = mdl_yq;
    ex.sq = mdl_sq;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end else begin
      got = sb_q.pop_front();
      assert (y_q === got.yq) else begin
        n_fail++;
        $error("FAIL %s y_q: observed %h expected %h", tag, y_q, got.yq);
      end
      n_vec++;
      assert (sel_q === got.sq) else begin
        n_fail++;
        $error("FAIL %s sel_q: observed %b expected %b", tag, sel_q, got.sq);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    i0     = 8'h00;
    i1     = 8'h00;
    sel    = 1'b0;
    w1_en  = 1'b0;
    w1_i0  = 1'b0;
    w1_i1  = 1'b0;
    w1_sel = 1'b0;
    mdl_yq = 8'h00;
    mdl_sq = 1'b0;

    // Truth table (i0,i1,sel), WIDTH=1, en=0
    w1_vec(1'b0, 1'b0, 1'b0, 1'b0);
    w1_vec(1'b0, 1'b0, 1'b1, 1'b0);
    w1_vec(1'b0, 1'b1, 1'b0, 1'b0);
    w1_vec(1'b0, 1'b1, 1'b1, 1'b1);
    w1_vec(1'b1, 1'b0, 1'b0, 1'b1);
    w1_vec(1'b1, 1'b0, 1'b1, 1'b0);
    w1_vec(1'b1, 1'b1, 1'b0, 1'b1);
    w1_vec(1'b1, 1'b1, 1'b1, 1'b1);
    // Unknown select with agreeing inputs still resolves
    w1_vec(1'b1, 1'b1, 1'bx, 1'b1);

    @(posedge clk);
    #1;

    // Reset held two edges with en=1, sel=1
    step("rst0", 1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 8'h34);
    step("rst1", 1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 8'h34);

    // Alternating select, one-edge latency
    step("lat0", 1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11);
    step("lat1", 1'b0, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22);
    step("lat2", 1'b0, 1'b1, 8'h11, 8'h22, 1'b0, 8'h11);
    step("lat3", 1'b0, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22);

    // Enable low: registers hold 22/1 while inputs change
    step("hold0", 1'b0, 1'b0, 8'h11, 8'h99, 1'b0, 8'h11);
    step("hold1", 1'b0, 1'b0, 8'h11, 8'h99, 1'b0, 8'h11);
    step("hold2", 1'b0, 1'b0, 8'h11, 8'h99, 1'b0, 8'h11);
    n_vec++;
    assert (y_q === 8'h22 && sel_q === 1'b1) else begin
      n_fail++;
      $error("FAIL hold_abs: observed %h/%b expected 22/1", y_q, sel_q);
    end

    // Mid-stream reset pulse, then resume
    step("mid0", 1'b0, 1'b1, 8'h33, 8'h44, 1'b1, 8'h44);
    step("mid_rst", 1'b1, 1'b1, 8'h55, 8'h66, 1'b0, 8'h55);
    n_vec++;
    assert (y_q === 8'hA5 && sel_q === 1'b0) else begin
      n_fail++;
      $error("FAIL mid_rst_abs: observed %h/%b expected a5/0", y_q, sel_q);
    end
    step("mid_res", 1'b0, 1'b1, 8'h55, 8'h66, 1'b1, 8'h66);

    // Equal inputs, sel toggling
    step("eq0", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFF);
    step("eq1", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF);
    step("eq2", 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFF);

    // Unknown select on the word path: differing bits go X, not i0
    step("selx", 1'b0, 1'b0, 8'hF0, 8'hF5, 1'bx, 8'b1111_0x0x);

    // WIDTH=1 instance was reset and never enabled
    n_vec++;
    assert (w1_y_q === 1'b0 && w1_sel_q === 1'b0) else begin
      n_fail++;
      $error("FAIL w1_regs: observed %b/%b expected 0/0", w1_y_q, w1_sel_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
